// File: rtl/core_ifq.sv
// Instruction queue between fetch and decode: in-order {pc, instr} FIFO with
// valid/ready to decode, early halt to fetch, sticky overflow and redirect flush.
module core_ifq #(
   parameter int DEPTH = 4,
   parameter int SKID  = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_if_pc,
   input  logic [31:0] i_if_instr,
   input  logic        i_if_busy,
   input  logic        i_flush,
   input  logic        i_id_ready,
   output logic        o_id_valid,
   output logic [31:0] o_id_pc,
   output logic [31:0] o_id_instr,
   output logic        o_ifq_halt,
   output logic        o_ifq_ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifq_entry_t;

   ifq_entry_t        r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]     r_count;
   logic              r_ovf;

   logic w_push, w_pop, w_full, w_wr, w_drop;

   assign w_push = !i_if_busy && !i_flush;
   assign w_pop  = o_id_valid && i_id_ready;
   assign w_full = (r_count == CW'(DEPTH));
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign w_wr   = w_push && (!w_full || w_pop);
   assign w_drop = w_push && w_full && !w_pop;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_wr) r_count <= r_count - 1'b1;
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   // Storage carries no reset; only the pointers define what is live.
   always_ff @(posedge i_clk) begin
      if (i_rst && w_wr)
         r_mem[r_wr_ptr] <= '{pc: i_if_pc, instr: i_if_instr};
   end

   assign o_id_valid = (r_count != '0);
   assign o_id_pc    = r_mem[r_rd_ptr].pc;
   assign o_id_instr = r_mem[r_rd_ptr].instr;
   assign o_ifq_halt = (r_count >= CW'(DEPTH - SKID));
   assign o_ifq_ovf  = r_ovf;
endmodule

// File: tb/tb_core_ifq.sv
// Directed table-driven bench for core_ifq (DEPTH=4, SKID=1).
module tb_core_ifq;
   localparam logic [31:0] IMASK = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        rst, if_busy, flush, id_ready;
   logic [31:0] if_pc, if_instr;
   logic        id_valid, ifq_halt, ifq_ovf;
   logic [31:0] id_pc, id_instr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   core_ifq #(.DEPTH(4), .SKID(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc), .i_if_instr(if_instr),
      .i_if_busy(if_busy), .i_flush(flush), .i_id_ready(id_ready),
      .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_instr(id_instr),
      .o_ifq_halt(ifq_halt), .o_ifq_ovf(ifq_ovf)
   );

   typedef struct {
      logic        busy, fl, rdy;
      logic [31:0] pc;
      logic        ev;
      logic [31:0] epc;
      logic        eh, eo;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic busy, logic fl, logic rdy, logic [31:0] pc,
                               logic ev, logic [31:0] epc, logic eh, logic eo);
      vec_t v;
      v.busy = busy; v.fl = fl; v.rdy = rdy; v.pc = pc;
      v.ev = ev; v.epc = epc; v.eh = eh; v.eo = eo;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle at negedge, sample #1 after the following posedge.
   task automatic step(logic busy, logic fl, logic rdy, logic [31:0] pc);
      @(negedge clk);
      if_busy = busy; flush = fl; id_ready = rdy;
      if_pc = pc; if_instr = pc ^ IMASK;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(string tag, logic ev, logic [31:0] epc, logic eh, logic eo);
      chk({tag, ".valid"}, 32'(id_valid), 32'(ev));
      if (ev) begin
         chk({tag, ".pc"}, id_pc, epc);
         chk({tag, ".instr"}, id_instr, epc ^ IMASK);
      end
      chk({tag, ".halt"}, 32'(ifq_halt), 32'(eh));
      chk({tag, ".ovf"}, 32'(ifq_ovf), 32'(eo));
   endtask

   initial begin
      // busy flush rdy pc | valid pc halt ovf   (outputs after the edge)
      // streaming
      tbl.push_back(mk(0,0,1,32'h00, 1,32'h00,0,0));
      tbl.push_back(mk(0,0,1,32'h04, 1,32'h04,0,0));
      tbl.push_back(mk(0,0,1,32'h08, 1,32'h08,0,0));
      tbl.push_back(mk(1,0,1,32'h00, 0,32'h00,0,0));
      // fill to halt and full
      tbl.push_back(mk(0,0,0,32'h10, 1,32'h10,0,0));
      tbl.push_back(mk(0,0,0,32'h14, 1,32'h10,0,0));
      tbl.push_back(mk(0,0,0,32'h18, 1,32'h10,1,0));
      tbl.push_back(mk(0,0,0,32'h1c, 1,32'h10,1,0));
      // full with simultaneous push and pop
      tbl.push_back(mk(0,0,1,32'h40, 1,32'h14,1,0));
      tbl.push_back(mk(1,0,1,32'h00, 1,32'h18,1,0));
      tbl.push_back(mk(1,0,1,32'h00, 1,32'h1c,0,0));
      tbl.push_back(mk(1,0,0,32'h00, 1,32'h1c,0,0));
      tbl.push_back(mk(1,0,1,32'h00, 1,32'h40,0,0));
      // refill, then overflow drops 0x50
      tbl.push_back(mk(0,0,0,32'h44, 1,32'h40,0,0));
      tbl.push_back(mk(0,0,0,32'h48, 1,32'h40,1,0));
      tbl.push_back(mk(0,0,0,32'h4c, 1,32'h40,1,0));
      tbl.push_back(mk(0,0,0,32'h50, 1,32'h40,1,1));
      tbl.push_back(mk(1,0,1,32'h00, 1,32'h44,1,1));
      tbl.push_back(mk(1,0,1,32'h00, 1,32'h48,0,1));
      tbl.push_back(mk(1,0,1,32'h00, 1,32'h4c,0,1));
      tbl.push_back(mk(1,0,1,32'h00, 0,32'h00,0,1));
      // flush with push and ready, then back-to-back flush
      tbl.push_back(mk(0,0,0,32'h60, 1,32'h60,0,1));
      tbl.push_back(mk(0,0,0,32'h64, 1,32'h60,0,1));
      tbl.push_back(mk(0,0,0,32'h68, 1,32'h60,1,1));
      tbl.push_back(mk(0,1,1,32'h6c, 0,32'h00,0,1));
      tbl.push_back(mk(0,1,1,32'h70, 0,32'h00,0,1));
      tbl.push_back(mk(0,0,0,32'h100,1,32'h100,0,1));
      tbl.push_back(mk(1,0,1,32'h00, 0,32'h00,0,1));

      rst = 1'b0; if_busy = 1'b0; flush = 1'b0; id_ready = 1'b0;
      if_pc = 32'h0; if_instr = 32'h0;

      // Reset held 2 cycles with fetch pushing: nothing may enter.
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 32'hAA0 + 32'(i));
         expect_out($sformatf("reset%0d", i), 0, 32'h0, 0, 0);
      end
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].busy, tbl[i].fl, tbl[i].rdy, tbl[i].pc);
         expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eh, tbl[i].eo);
      end

      // Wrap-around: 10 push/pop pairs, each word seen the cycle after its push.
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 32'h200 + 32'(4 * i));
         expect_out($sformatf("wrap%0d", i), 1, 32'h200 + 32'(4 * i), 0, 1);
      end
      step(1, 0, 1, 32'h0);
      expect_out("wrap_end", 0, 32'h0, 0, 1);

      // Reset mid-operation clears queue and sticky overflow.
      step(0, 0, 0, 32'h300);
      step(0, 0, 0, 32'h304);
      expect_out("pre_rst", 1, 32'h300, 0, 1);
      rst = 1'b0;
      step(0, 1, 1, 32'h308);
      expect_out("mid_rst", 0, 32'h0, 0, 0);
      rst = 1'b1;
      step(0, 0, 0, 32'h30c);
      expect_out("post_rst", 1, 32'h30c, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
